// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential 32x32 RV32M multiplier.
package mul_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PROD_W    = 64;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned MUL_STEPS = 16;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_e;

  // Operation context captured at acceptance and held for the whole op.
  typedef struct packed {
    mul_op_e         op;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            neg;
  } mul_ctx_t;

  // Unsigned magnitude; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                input logic            is_signed);
    return (is_signed && x[XLEN-1]) ? XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/vedic_mul_8x8.sv
// Combinational 8x8 unsigned multiplier built Urdhva-style from 2x2 cells.
module vedic_mul_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p_c
);

  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic       c;
    logic [3:0] r;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c;
    r[3] = (x[1] & y[1]) & c;
    return r;
  endfunction

  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] ll, lh, hl, hh;
    ll = mul2(x[1:0], y[1:0]);
    lh = mul2(x[1:0], y[3:2]);
    hl = mul2(x[3:2], y[1:0]);
    hh = mul2(x[3:2], y[3:2]);
    return 8'(ll) + (8'(lh) << 2) + (8'(hl) << 2) + (8'(hh) << 4);
  endfunction

  // Four 4x4 cross products combined into the 16-bit result.
  always_comb begin
    logic [7:0] ll, lh, hl, hh;
    ll  = mul4(a[3:0], b[3:0]);
    lh  = mul4(a[3:0], b[7:4]);
    hl  = mul4(a[7:4], b[3:0]);
    hh  = mul4(a[7:4], b[7:4]);
    p_c = 16'(ll) + (16'(lh) << 4) + (16'(hl) << 4) + (16'(hh) << 8);
  end

endmodule

// File: rtl/mul_seq_32x32.sv
// Multi-cycle RV32M multiply: 16 byte partial products accumulated serially.
module mul_seq_32x32
  import mul_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  mul_state_e          state_q, state_d;
  mul_ctx_t            ctx_q;
  logic [PROD_W-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;

  mul_op_e             op_in_c;
  logic                s1_c, s2_c, accept_c;
  logic [1:0]          i_c, j_c;
  logic [BYTE_W-1:0]   a_byte_c, b_byte_c;
  logic [15:0]         pp_c;
  logic [5:0]          sh_c;
  logic [PROD_W-1:0]   acc_sum_c, prod_c;

  assign op_in_c  = mul_op_e'(op_i);
  assign s1_c     = (op_in_c == MULH) || (op_in_c == MULHSU);
  assign s2_c     = (op_in_c == MULH);
  assign accept_c = (state_q == IDLE) && valid_i && !flush_i;

  // Byte selection and placement of the current partial product.
  assign i_c       = cnt_q[1:0];
  assign j_c       = cnt_q[3:2];
  assign a_byte_c  = ctx_q.a_mag[{i_c, 3'b000} +: BYTE_W];
  assign b_byte_c  = ctx_q.b_mag[{j_c, 3'b000} +: BYTE_W];
  assign sh_c      = {3'(i_c) + 3'(j_c), 3'b000};
  assign acc_sum_c = acc_q + (PROD_W'(pp_c) << sh_c);
  assign prod_c    = ctx_q.neg ? PROD_W'(-acc_q) : acc_q;

  vedic_mul_8x8 u_vedic (
    .a   (a_byte_c),
    .b   (b_byte_c),
    .p_c (pp_c)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(MUL_STEPS - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Handshake outputs registered from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      ready_o <= (state_d == IDLE);
      valid_o <= (state_d == DONE);
    end
  end

  // Operand capture, accumulation and result sign fix-up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctx_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_o <= '0;
    end else if (accept_c) begin
      ctx_q.op    <= op_in_c;
      ctx_q.a_mag <= magnitude(rs1_i, s1_c);
      ctx_q.b_mag <= magnitude(rs2_i, s2_c);
      ctx_q.neg   <= (rs1_i[XLEN-1] & s1_c) ^ (rs2_i[XLEN-1] & s2_c);
      acc_q       <= '0;
      cnt_q       <= '0;
    end else if (!flush_i && state_q == CALC) begin
      acc_q <= acc_sum_c;
      cnt_q <= CNT_W'(cnt_q + 1'b1);
    end else if (!flush_i && state_q == FIX) begin
      result_o <= (ctx_q.op == MUL) ? prod_c[XLEN-1:0] : prod_c[PROD_W-1:XLEN];
    end
  end

endmodule

// File: tb/tb_mul_seq_32x32.sv
// Scoreboard bench for mul_seq_32x32: reference model vs. DUT result stream.
module tb_mul_seq_32x32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i, valid_i, ready_o, valid_o, ready_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i, rs2_i, result_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  always #5 clk = ~clk;

  mul_seq_32x32 dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sign-extend per op and take the mod-2^64 product.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request until accepted, then scramble inputs and push expectation.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input string tag);
    bit ok;
    ok      = 1'b0;
    valid_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    for (int k = 0; k < 40; k++) begin
      if (ready_o) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    valid_i = 1'b0;
    op_i    = 2'($urandom);
    rs1_i   = $urandom;
    rs2_i   = $urandom;
    check({tag, " accept"}, 64'(ok), 64'(1));
    if (ok) sb_q.push_back(model(op, a, b));
  endtask

  // Wait for valid_o, check latency and value, apply backpressure, consume.
  task automatic receive(input string tag, input int hold);
    int          lat;
    bit          rdy_hi;
    logic [31:0] exp, held;
    lat    = 0;
    rdy_hi = 1'b0;
    while (!valid_o && lat < 40) begin
      step();
      lat++;
      rdy_hi |= ready_o;
    end
    check({tag, " latency"}, 64'(lat), 64'(17));
    check({tag, " ready_low"}, 64'(rdy_hi), 64'(0));
    if (sb_q.size() == 0) begin
      check({tag, " sb_empty"}, 64'(1), 64'(0));
      exp = 32'hx;
    end else begin
      exp = sb_q.pop_front();
    end
    check(tag, 64'(result_o), 64'(exp));
    held = result_o;
    for (int k = 0; k < hold; k++) begin
      step();
      check({tag, " hold_valid"}, 64'(valid_o), 64'(1));
      check({tag, " hold_result"}, 64'(result_o), 64'(held));
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check({tag, " idle_ready"}, 64'(ready_o), 64'(1));
    check({tag, " idle_valid"}, 64'(valid_o), 64'(0));
    check({tag, " idle_result"}, 64'(result_o), 64'(held));
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      step();
      seen |= valid_o;
    end
    check({tag, " no_valid"}, 64'(seen), 64'(0));
  endtask

  initial begin
    rst_n   = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    op_i    = '0;
    rs1_i   = '0;
    rs2_i   = '0;
    repeat (3) step();
    check("rst ready", 64'(ready_o), 64'(1));
    check("rst valid", 64'(valid_o), 64'(0));
    check("rst result", 64'(result_o), 64'(0));
    rst_n = 1'b1;

    send(OP_MUL, 32'd7, 32'd6, "mul7x6");
    receive("mul7x6", 0);
    check("mul7x6 const", 64'(result_o), 64'h2A);

    send(OP_MULH, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    receive("mulh_min", 0);
    check("mulh_min const", 64'(result_o), 64'h4000_0000);

    send(OP_MULH, 32'hFFFF_FFFF, 32'h0000_0002, "mulh_neg");
    receive("mulh_neg", 0);

    send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    receive("mulhu_max", 0);
    check("mulhu_max const", 64'(result_o), 64'hFFFF_FFFE);

    send(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    receive("mul_max", 10);
    check("mul_max const", 64'(result_o), 64'h1);

    send(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max");
    receive("mulhsu_max", 0);

    send(OP_MULHSU, 32'h8000_0000, 32'h0, "mulhsu_zero");
    receive("mulhsu_zero", 0);

    for (int n = 0; n < 6; n++) begin
      send(2'(n % 4), $urandom, $urandom, $sformatf("rand%0d", n));
      receive($sformatf("rand%0d", n), 0);
    end

    // Flush together with valid in IDLE must not accept.
    valid_i = 1'b1;
    flush_i = 1'b1;
    step();
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("idle_flush ready", 64'(ready_o), 64'(1));
    expect_quiet("idle_flush", 20);

    // Flush in the fifth CALC cycle.
    send(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, "flush_op");
    repeat (4) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush ready", 64'(ready_o), 64'(1));
    check("flush valid", 64'(valid_o), 64'(0));
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    expect_quiet("flush", 25);
    send(OP_MULHU, 32'd3, 32'd5, "post_flush");
    receive("post_flush", 0);
    check("post_flush const", 64'(result_o), 64'h0);

    // Async reset in the ninth CALC cycle.
    send(OP_MULH, 32'hDEAD_BEEF, 32'h1357_9BDF, "reset_op");
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    check("areset ready", 64'(ready_o), 64'(1));
    check("areset valid", 64'(valid_o), 64'(0));
    check("areset result", 64'(result_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    expect_quiet("reset", 25);
    send(OP_MULHU, 32'd3, 32'd5, "post_reset");
    receive("post_reset", 0);

    check("sb drained", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
